fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch-side controller for the multicycle CPU. It is the consumer and driver of the program counter interface.
- It samples the current PC and fetches the instruction word from instruction memory over a req/ack handshake, then latches it into the instruction register.
- It then writes the next PC back through the PC's load-enable and next-value inputs, either sequential PC+4 or a branch/jump redirect.
- It sits between the main control FSM, the PC register and the instruction memory port.

Parameters:
IMEM_BASE, 32'h0000_3000, byte address of the first instruction word
IMEM_WORDS, 1024, number of 32-bit words in instruction memory (legal range IMEM_BASE .. IMEM_BASE+4*IMEM_WORDS-4)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted = 1 despite the name)
PC_Addr  input  32  current PC value from the PC register
new_PC  output  32  next PC value to the PC register
PC_enable  output  1  PC load enable, one-cycle pulse
fetch_start  input  1  control FSM request to fetch the instruction at PC_Addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  branch/jump target byte address
imem_req  output  1  instruction memory read request
imem_addr  output  32  instruction memory byte address
imem_ack  input  1  read data valid this cycle
imem_rdata  input  32  instruction word
IR  output  32  instruction register
ir_valid  output  1  one-cycle pulse: IR updated
fetch_busy  output  1  high in REQ and UPDATE states
fetch_fault  output  1  sticky alignment/range fault
fault_addr  output  32  offending address

Behaviour:
- All outputs are registered.
- Reset (rst_n=1, asynchronous):
  - state=IDLE
  - new_PC=0, PC_enable=0
  - imem_req=0, imem_addr=0
  - IR=0, ir_valid=0
  - fetch_fault=0, fault_addr=0
  - redirect pending flag cleared
- Reset mid-fetch: the request drops immediately and the returned ack is ignored.
- FSM states: IDLE, REQ, UPDATE, FAULT.
- IDLE, checked in priority order at each edge:
  - (a) redirect_valid or pending flag set: if the target (or the pending target) is legal, load new_PC=target, PC_enable=1, clear pending, go to UPDATE. Otherwise go to FAULT.
  - (b) else if fetch_start: if PC_Addr is legal, set imem_addr=PC_Addr, imem_req=1, go to REQ. Otherwise go to FAULT.
  - fetch_start in the same cycle as a redirect is dropped; the control FSM must reissue it.
- Legality: address[1:0]==0 and IMEM_BASE <= address <= IMEM_BASE+4*(IMEM_WORDS-1).
- REQ:
  - imem_req stays 1 and imem_addr stays stable until imem_ack is sampled high. Wait time is unbounded.
  - On the ack edge:
    - IR=imem_rdata and ir_valid=1.
    - imem_req=0.
    - PC_enable=1.
    - new_PC = pending target if a redirect arrived during REQ (or at the ack edge), else imem_addr+4, truncated to 32 bits.
    - Pending is cleared; go to UPDATE.
  - A redirect with an illegal target, or an illegal sequential next PC, goes to FAULT instead of UPDATE. No PC_enable is issued; IR is still updated.
  - fetch_start is ignored while in REQ.
- UPDATE:
  - Lasts exactly one cycle, with PC_enable=1 and ir_valid per above.
  - fetch_start is ignored, because PC_Addr is stale until the next edge.
  - redirect_valid in UPDATE sets the pending flag and target, which are served in the next IDLE cycle.
  - Next state is IDLE; PC_enable and ir_valid return to 0.
- FAULT:
  - fetch_fault=1 and fault_addr = offending address.
  - Outputs are quiescent (imem_req=0, PC_enable=0).
  - Exit is only by reset.
- Latency: fetch_start sampled at edge 0 gives imem_req=1 after edge 0. Ack sampled at edge k gives IR/ir_valid/PC_enable after edge k, and the PC updates at edge k+1.
- At most one PC_enable pulse is issued per fetch or redirect. PC_enable is never high on two consecutive cycles.

Test Plan:
- Reset, then fetch_start with PC_Addr=0x3000. Memory acks 2 cycles after the request with 0x2008_0005. Required: IR=0x20080005, ir_valid 1 cycle, PC_enable 1 cycle with new_PC=0x3004, fetch_busy low afterwards.
- Redirect during REQ: redirect_target=0x3040 asserted while waiting for ack at PC 0x3004. Required: new_PC=0x3040 (not 0x3008), IR still latched.
- Redirect while in IDLE with target 0x3100. Required: PC_enable after 1 edge, new_PC=0x3100, imem_req stays 0.
- fetch_start with PC_Addr=0x3002. Required: FAULT, fetch_fault=1, fault_addr=0x3002, no imem_req. Reset clears all of these.
- Last legal word 0x3FFC (IMEM_WORDS=1024). Required: fetch completes, then FAULT with fault_addr=0x4000 and no PC_enable.
- Assert rst_n mid-REQ. Required: imem_req=0 immediately (asynchronous). A late ack is ignored and IR stays 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-side controller for the multicycle CPU.
//
// It samples the PC and reads one instruction word from instruction memory
// over a req/ack handshake, then latches the word into IR. It then writes
// the next PC (sequential +4 or a branch/jump redirect) back to the PC
// register through new_PC/PC_enable. Any illegal address (misaligned or
// outside the instruction memory window) parks the block in a sticky
// FAULT state that only reset clears.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, ACTIVE HIGH despite the name
//   PC_Addr         current PC from the PC register
//   new_PC          next PC value to the PC register
//   PC_enable       one-cycle PC load pulse
//   fetch_start     control FSM request to fetch at PC_Addr
//   redirect_valid  branch/jump taken this cycle
//   redirect_target branch/jump target byte address
//   imem_req        instruction memory read request (held until ack)
//   imem_addr       instruction memory byte address
//   imem_ack        read data valid this cycle
//   imem_rdata      instruction word
//   IR              instruction register
//   ir_valid        one-cycle pulse: IR updated
//   fetch_busy      high while in REQ or UPDATE
//   fetch_fault     sticky alignment/range fault
//   fault_addr      offending address
module fetch_ctrl #(
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_Addr,
  output logic [31:0] new_PC,
  output logic        PC_enable,
  input  logic        fetch_start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
);

  // Byte address of the last legal instruction word.
  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(4 * (IMEM_WORDS - 1));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_UPDATE = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  // Every output is a flop; they travel together as one registered bundle.
  typedef struct packed {
    logic [31:0] new_pc;
    logic        pc_en;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ir;
    logic        ir_vld;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;
  } out_t;

  state_e      state_q, state_d;
  out_t        out_q, out_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        redir_any;
  logic [31:0] redir_tgt;
  logic [31:0] ack_next_pc;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IMEM_BASE) && (a <= IMEM_LAST);
  endfunction

  // A live redirect is newer than a parked one, so it wins when both exist.
  assign redir_any   = redirect_valid | pend_q;
  assign redir_tgt   = redirect_valid ? redirect_target : pend_tgt_q;
  // Next PC chosen at the ack edge; the +4 wraps silently at 32 bits.
  assign ack_next_pc = redir_any ? redir_tgt : (out_q.addr + 32'd4);

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    out_d.pc_en  = 1'b0;
    out_d.ir_vld = 1'b0;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;

    unique case (state_q)
      S_IDLE: begin
        if (redir_any) begin
          // Redirect has priority; a simultaneous fetch_start is dropped.
          pend_d = 1'b0;
          if (addr_legal(redir_tgt)) begin
            out_d.new_pc = redir_tgt;
            out_d.pc_en  = 1'b1;
            state_d      = S_UPDATE;
          end else begin
            out_d.fault      = 1'b1;
            out_d.fault_addr = redir_tgt;
            state_d          = S_FAULT;
          end
        end else if (fetch_start) begin
          if (addr_legal(PC_Addr)) begin
            out_d.addr = PC_Addr;
            out_d.req  = 1'b1;
            state_d    = S_REQ;
          end else begin
            out_d.fault      = 1'b1;
            out_d.fault_addr = PC_Addr;
            state_d          = S_FAULT;
          end
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          // IR is captured even when the next PC turns out to be illegal.
          out_d.ir     = imem_rdata;
          out_d.ir_vld = 1'b1;
          out_d.req    = 1'b0;
          pend_d       = 1'b0;
          if (addr_legal(ack_next_pc)) begin
            out_d.new_pc = ack_next_pc;
            out_d.pc_en  = 1'b1;
            state_d      = S_UPDATE;
          end else begin
            out_d.fault      = 1'b1;
            out_d.fault_addr = ack_next_pc;
            state_d          = S_FAULT;
          end
        end else if (redirect_valid) begin
          // Park the redirect; it replaces the +4 at the ack edge.
          pend_d     = 1'b1;
          pend_tgt_d = redirect_target;
        end
      end

      S_UPDATE: begin
        // PC_Addr is stale this cycle, so fetch_start is ignored. A redirect
        // here is parked and served from IDLE on the next cycle.
        if (redirect_valid) begin
          pend_d     = 1'b1;
          pend_tgt_d = redirect_target;
        end
        state_d = S_IDLE;
      end

      S_FAULT: begin
        out_d.req = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    out_d.busy = (state_d == S_REQ) || (state_d == S_UPDATE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign new_PC      = out_q.new_pc;
  assign PC_enable   = out_q.pc_en;
  assign imem_req    = out_q.req;
  assign imem_addr   = out_q.addr;
  assign IR          = out_q.ir;
  assign ir_valid    = out_q.ir_vld;
  assign fetch_busy  = out_q.busy;
  assign fetch_fault = out_q.fault;
  assign fault_addr  = out_q.fault_addr;

endmodule
